card_dealer: RTL and testbench



---
 rtl/card_dealer.sv | 137 +++++++++++++
 tb/tb_card_dealer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/card_dealer.sv
// card_dealer: one-deck card source for the blackjack game FSM.
// Serves one random card per request from a 52-card deck (13 ranks x 4).
// A free-running 16-bit Fibonacci LFSR picks the starting rank. Ranks that
// are used up are skipped by probing forward, wrapping from rank 13 to rank 1.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   req          single-cycle draw request
//   shuffle      single-cycle refill of the full deck (aborts a draw in progress)
//   card_value   blackjack value of the last dealt card (1..10, J/Q/K = 10)
//   card_rank    rank of the last dealt card (1 = A .. 13 = K)
//   card_valid   one-cycle pulse when a new card is presented
//   busy         high while a draw is searching
//   cards_left   cards remaining in the deck (0..52)
//   deck_empty   high when cards_left == 0
//   req_dropped  one-cycle pulse: req ignored because deck empty or busy
//
// state  | meaning
// IDLE   | waiting for req/shuffle
// SEARCH | probing rank counts for a nonzero entry
module card_dealer #(
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter int          DECK_CARDS = 52
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       shuffle,
    output logic [3:0] card_value,
    output logic [3:0] card_rank,
    output logic       card_valid,
    output logic       busy,
    output logic [5:0] cards_left,
    output logic       deck_empty,
    output logic       req_dropped
);

    localparam logic [5:0] FULL_DECK = 6'(DECK_CARDS);

    typedef enum logic {
        IDLE   = 1'b0,
        SEARCH = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] lfsr;
    logic [2:0]  rank_cnt [0:12];
    logic [3:0]  probe, probe_nxt;
    logic [3:0]  start_idx;
    logic [5:0]  left;
    logic        hit;
    logic        refill;
    logic        take;
    logic        drop;

    // Fold the 0..15 nibble into 0..12 with a single conditional subtract.
    assign start_idx = (lfsr[3:0] >= 4'd13) ? (lfsr[3:0] - 4'd13) : lfsr[3:0];
    assign hit       = (rank_cnt[probe] != 3'd0);

    always_comb begin
        state_nxt = state;
        probe_nxt = probe;
        refill    = 1'b0;
        take      = 1'b0;
        drop      = 1'b0;
        case (state)
            IDLE: begin
                // A req in the same cycle as shuffle is discarded without a drop pulse.
                if (shuffle) begin
                    refill = 1'b1;
                end else if (req) begin
                    if (left == 6'd0) begin
                        drop = 1'b1;
                    end else begin
                        probe_nxt = start_idx;
                        state_nxt = SEARCH;
                    end
                end
            end
            SEARCH: begin
                if (shuffle) begin
                    refill    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    drop = req;
                    if (hit) begin
                        take      = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        probe_nxt = (probe == 4'd12) ? 4'd0 : probe + 4'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            lfsr        <= SEED;
            probe       <= 4'd0;
            left        <= FULL_DECK;
            card_value  <= 4'd0;
            card_rank   <= 4'd0;
            card_valid  <= 1'b0;
            req_dropped <= 1'b0;
            for (int i = 0; i < 13; i++) begin
                rank_cnt[i] <= 3'd4;
            end
        end else begin
            state       <= state_nxt;
            lfsr        <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            probe       <= probe_nxt;
            card_valid  <= take;
            req_dropped <= drop;
            if (refill) begin
                left <= FULL_DECK;
                for (int i = 0; i < 13; i++) begin
                    rank_cnt[i] <= 3'd4;
                end
            end else if (take) begin
                rank_cnt[probe] <= rank_cnt[probe] - 3'd1;
                left            <= left - 6'd1;
                card_rank       <= probe + 4'd1;
                // Index 9..12 are 10, J, Q, K, all worth 10.
                card_value      <= (probe >= 4'd9) ? 4'd10 : probe + 4'd1;
            end
        end
    end

    assign busy       = (state == SEARCH);
    assign cards_left = left;
    assign deck_empty = (left == 6'd0);

endmodule

// File: tb/tb_card_dealer.sv
// tb_card_dealer: directed-plus-random bench for card_dealer.
// A reference deck (per-rank counts) and the LFSR recurrence predict which
// rank each draw returns and how many cycles it takes.
module tb_card_dealer;

    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic       shuffle;
    logic [3:0] card_value;
    logic [3:0] card_rank;
    logic       card_valid;
    logic       busy;
    logic [5:0] cards_left;
    logic       deck_empty;
    logic       req_dropped;

    card_dealer #(.SEED(SEED), .DECK_CARDS(52)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .shuffle    (shuffle),
        .card_value (card_value),
        .card_rank  (card_rank),
        .card_valid (card_valid),
        .busy       (busy),
        .cards_left (cards_left),
        .deck_empty (deck_empty),
        .req_dropped(req_dropped)
    );

    always #5 clk = ~clk;

    logic [15:0] m_lfsr;
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= SEED;
        else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    int mc [13];
    int mleft;
    int hist [13];
    int tens;
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic model_refill();
        for (int i = 0; i < 13; i++) mc[i] = 4;
        mleft = 52;
    endtask

    // Starts on a falling edge, returns on a falling edge one cycle after card_valid.
    task automatic do_draw(input bit busy_req, output int rank_o, output int lat_o);
        int s, idx, k, lat, drops;
        bit got;
        s = int'(m_lfsr[3:0]);
        if (s >= 13) s -= 13;
        idx = s;
        k   = 0;
        while (mc[idx] == 0 && k < 13) begin
            idx = (idx + 1) % 13;
            k++;
        end
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        chk("busy_search", busy, 1);
        if (busy_req) req = 1'b1;
        lat   = 1;
        got   = 1'b0;
        drops = 0;
        while (!got && lat < 20) begin
            @(negedge clk);
            req = 1'b0;
            lat++;
            if (req_dropped) drops++;
            if (card_valid) got = 1'b1;
        end
        chk("valid_seen", got, 1);
        chk("latency", lat, 2 + k);
        chk("rank", card_rank, idx + 1);
        chk("value", card_value, (idx + 1 > 10) ? 10 : idx + 1);
        mc[idx]--;
        mleft--;
        chk("cards_left", cards_left, mleft);
        chk("deck_empty", deck_empty, (mleft == 0));
        chk("busy_req_drop", drops, busy_req);
        @(negedge clk);
        chk("valid_pulse", card_valid, 0);
        chk("busy_idle", busy, 0);
        rank_o = idx + 1;
        lat_o  = lat;
    endtask

    task automatic watch(input int n, output int valids, output int drops, output int busys);
        valids = 0;
        drops  = 0;
        busys  = 0;
        repeat (n) begin
            @(negedge clk);
            if (card_valid)  valids++;
            if (req_dropped) drops++;
            if (busy)        busys++;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_left"},  cards_left, 52);
        chk({tag, "_empty"}, deck_empty, 0);
        chk({tag, "_valid"}, card_valid, 0);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_value"}, card_value, 0);
        chk({tag, "_rank"},  card_rank, 0);
        chk({tag, "_drop"},  req_dropped, 0);
    endtask

    initial begin
        int r, l, w, v, d, b, last_rank;
        req     = 1'b0;
        shuffle = 1'b0;
        rst     = 1'b1;
        tens    = 0;
        for (int i = 0; i < 13; i++) hist[i] = 0;
        model_refill();
        repeat (5) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);

        // Drain the whole deck with random spacing and occasional busy reqs.
        last_rank = 0;
        for (int n = 0; n < 52; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_draw($urandom_range(0, 3) == 0, r, l);
            hist[r-1]++;
            if (r >= 10) tens++;
            chk("lat_range", (l >= 2 && l <= 14), 1);
            last_rank = r;
        end
        for (int i = 0; i < 13; i++) chk("rank_hist", hist[i], 4);
        chk("tens_hist", tens, 16);
        chk("drained_left", cards_left, 0);
        chk("drained_empty", deck_empty, 1);

        // Request on an empty deck.
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        chk("empty_busy", busy, 0);
        chk("empty_drop", req_dropped, 1);
        watch(16, v, d, b);
        chk("empty_valids", v, 0);
        chk("empty_extra_drops", d, 0);
        chk("empty_left", cards_left, 0);

        shuffle = 1'b1;
        @(negedge clk);
        shuffle = 1'b0;
        model_refill();
        chk("shuffle_left", cards_left, 52);
        chk("shuffle_empty", deck_empty, 0);
        chk("shuffle_rank_hold", card_rank, last_rank);

        // Aces first: four draws starting at index 0 take the aces, the fifth skips to rank 2.
        for (int a = 0; a < 5; a++) begin
            w = 0;
            while (!(m_lfsr[3:0] == 4'd0 || m_lfsr[3:0] == 4'd13) && w < 300) begin
                @(negedge clk);
                w++;
            end
            chk("ace_wait", (w < 300), 1);
            do_draw(1'b0, r, l);
            if (a < 4) begin
                chk("ace_rank", r, 1);
            end else begin
                chk("skip_rank", card_rank, 2);
                chk("skip_lat", l, 3);
            end
        end

        // req and shuffle together in IDLE after ten draws.
        shuffle = 1'b1;
        @(negedge clk);
        shuffle = 1'b0;
        model_refill();
        for (int n = 0; n < 10; n++) do_draw(1'b0, r, l);
        chk("ten_left", cards_left, 42);
        req     = 1'b1;
        shuffle = 1'b1;
        @(negedge clk);
        req     = 1'b0;
        shuffle = 1'b0;
        model_refill();
        chk("rs_left", cards_left, 52);
        chk("rs_drop_now", req_dropped, 0);
        watch(16, v, d, b);
        chk("rs_valids", v, 0);
        chk("rs_drops", d, 0);
        chk("rs_busy", b, 0);

        // Shuffle one cycle after req aborts the draw.
        for (int n = 0; n < 3; n++) do_draw(1'b0, r, l);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        chk("abort_busy_pre", busy, 1);
        shuffle = 1'b1;
        @(negedge clk);
        shuffle = 1'b0;
        model_refill();
        chk("abort_busy", busy, 0);
        chk("abort_left", cards_left, 52);
        chk("abort_valid_now", card_valid, 0);
        watch(16, v, d, b);
        chk("abort_valids", v, 0);

        // Asynchronous reset in the middle of a search.
        for (int n = 0; n < 2; n++) do_draw(1'b0, r, l);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        chk("rst_busy_pre", busy, 1);
        rst = 1'b1;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        rst = 1'b0;
        model_refill();
        @(negedge clk);
        do_draw(1'b0, r, l);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
